analog_scan_sequencer: RTL and testbench

//  Wishbone-controlled scheduler that time-shares one analog front-end (mux + sample/hold + ADC on user IOs)

---
 rtl/analog_scan_pkg.sv | 31 +++
 rtl/analog_scan_regs.sv | 126 ++++++++++++
 rtl/analog_scan_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_analog_scan_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/analog_scan_pkg.sv
// Shared constants for the analog scan sequencer: register offsets, bit positions, FSM states.
package analog_scan_pkg;

    localparam int MAX_NCH = 16;

    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_TIMING = 8'h04;
    localparam logic [7:0] OFS_STATUS = 8'h08;
    localparam logic [1:0] DATA_WIN   = 2'b01;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CONT     = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_ABORT    = 3;
    localparam int CTRL_MASK_LSB = 8;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_CH_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CAPTURE,
        ST_NEXT,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/analog_scan_regs.sv
// Wishbone slave for the scan sequencer: address decode, single-cycle ack, control/timing/status
// registers and the per-channel result array.
module analog_scan_regs
    import analog_scan_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          NCH      = 8,
    parameter int          DW       = 12,
    parameter int          CSW      = $clog2(NCH)
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic [31:0]     wbs_dat_o,
    output logic            wbs_ack_o,
    input  logic            busy,
    input  logic [3:0]      cur_ch,
    input  logic            done_set,
    input  logic            capture_en,
    input  logic [CSW-1:0]  capture_ch,
    input  logic [DW-1:0]   adc_data,
    output logic            start_pulse,
    output logic            abort_pulse,
    output logic            continuous,
    output logic            irq_en,
    output logic [NCH-1:0]  chan_mask,
    output logic [15:0]     settle_cycles,
    output logic [15:0]     hold_cycles,
    output logic            done
);

    localparam logic [4:0] NCH5 = 5'(NCH);

    logic                hit;
    logic                rd_en;
    logic                wr_en;
    logic [7:0]          ofs;
    logic [3:0]          data_idx;
    logic                data_hit;
    logic [31:0]         rd_data;
    logic [MAX_NCH-1:0]  mask_q;
    logic [DW-1:0]       data_q [NCH];

    assign ofs      = wbs_adr_i[7:0];
    assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // Gating with the current ack forces one idle cycle between back-to-back acks.
    assign rd_en    = hit & ~wbs_ack_o;
    assign wr_en    = rd_en & wbs_we_i;
    assign data_idx = ofs[5:2];
    assign data_hit = (ofs[7:6] == DATA_WIN) && (ofs[1:0] == 2'b00) && ({1'b0, data_idx} < NCH5);

    assign chan_mask = mask_q[NCH-1:0];

    always_comb begin
        rd_data = '0;
        if (ofs == OFS_CTRL) begin
            rd_data[CTRL_CONT]                          = continuous;
            rd_data[CTRL_IRQ_EN]                        = irq_en;
            rd_data[CTRL_MASK_LSB +: MAX_NCH]           = mask_q;
        end else if (ofs == OFS_TIMING) begin
            rd_data = {hold_cycles, settle_cycles};
        end else if (ofs == OFS_STATUS) begin
            rd_data[STAT_BUSY]          = busy;
            rd_data[STAT_DONE]          = done;
            rd_data[STAT_CH_LSB +: 4]   = cur_ch;
        end else if (data_hit) begin
            rd_data = 32'(data_q[data_idx[CSW-1:0]]);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            start_pulse   <= 1'b0;
            abort_pulse   <= 1'b0;
            continuous    <= 1'b0;
            irq_en        <= 1'b0;
            mask_q        <= '0;
            settle_cycles <= '0;
            hold_cycles   <= '0;
            done          <= 1'b0;
        end else begin
            wbs_ack_o   <= rd_en;
            wbs_dat_o   <= rd_en ? rd_data : '0;
            start_pulse <= wr_en && (ofs == OFS_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_START];
            abort_pulse <= wr_en && (ofs == OFS_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_ABORT];

            if (wr_en && (ofs == OFS_CTRL)) begin
                if (wbs_sel_i[0]) begin
                    continuous <= wbs_dat_i[CTRL_CONT];
                    irq_en     <= wbs_dat_i[CTRL_IRQ_EN];
                end
                if (wbs_sel_i[1]) mask_q[7:0]  <= wbs_dat_i[15:8];
                if (wbs_sel_i[2]) mask_q[15:8] <= wbs_dat_i[23:16];
            end

            if (wr_en && (ofs == OFS_TIMING)) begin
                if (wbs_sel_i[0]) settle_cycles[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) settle_cycles[15:8] <= wbs_dat_i[15:8];
                if (wbs_sel_i[2]) hold_cycles[7:0]    <= wbs_dat_i[23:16];
                if (wbs_sel_i[3]) hold_cycles[15:8]   <= wbs_dat_i[31:24];
            end

            // A scan completing in the same cycle as a W1C keeps done set.
            if (done_set)
                done <= 1'b1;
            else if (wr_en && (ofs == OFS_STATUS) && wbs_sel_i[0] && wbs_dat_i[STAT_DONE])
                done <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NCH; i++) data_q[i] <= '0;
        end else if (capture_en) begin
            data_q[capture_ch] <= adc_data;
        end
    end

endmodule

// File: rtl/analog_scan_sequencer.sv
// Time-shares one analog front-end across NCH channels: select, settle, sample, capture, repeat.
// Optional ANALOG_SCAN_LA_EN adds an LA rising-edge start input alongside the Wishbone start.
module analog_scan_sequencer
    import analog_scan_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          NCH      = 8,
    parameter int          DW       = 12,
    parameter int          CSW      = $clog2(NCH)
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic [31:0]     wbs_dat_o,
    output logic            wbs_ack_o,
    output logic [CSW-1:0]  chan_sel_o,
    output logic            sample_o,
    input  logic [DW-1:0]   adc_data_i,
    output logic            irq_o
`ifdef ANALOG_SCAN_LA_EN
    ,
    input  logic            la_start_i
`endif
);

    scan_state_t     state;
    logic [15:0]     cnt;
    logic [15:0]     settle_lat;
    logic [15:0]     hold_lat;
    logic [CSW-1:0]  tgt_ch;
    logic [3:0]      cur_ch;
    logic            start_pulse;
    logic            abort_pulse;
    logic            start_req;
    logic            continuous;
    logic            irq_en;
    logic            done;
    logic [NCH-1:0]  chan_mask;
    logic [15:0]     settle_cycles;
    logic [15:0]     hold_cycles;
    logic            first_found;
    logic [CSW-1:0]  first_ch;
    logic            next_found;
    logic [CSW-1:0]  next_ch;

    analog_scan_regs #(
        .BASE_ADR (BASE_ADR),
        .NCH      (NCH),
        .DW       (DW),
        .CSW      (CSW)
    ) u_regs (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_dat_o     (wbs_dat_o),
        .wbs_ack_o     (wbs_ack_o),
        .busy          (state != ST_IDLE),
        .cur_ch        (cur_ch),
        .done_set      ((state == ST_DONE) && !abort_pulse),
        .capture_en    (state == ST_CAPTURE),
        .capture_ch    (chan_sel_o),
        .adc_data      (adc_data_i),
        .start_pulse   (start_pulse),
        .abort_pulse   (abort_pulse),
        .continuous    (continuous),
        .irq_en        (irq_en),
        .chan_mask     (chan_mask),
        .settle_cycles (settle_cycles),
        .hold_cycles   (hold_cycles),
        .done          (done)
    );

    assign irq_o = done & irq_en;

    always_comb begin
        cur_ch = '0;
        cur_ch[CSW-1:0] = chan_sel_o;
    end

`ifdef ANALOG_SCAN_LA_EN
    logic la_q;
    logic la_q2;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            la_q  <= 1'b0;
            la_q2 <= 1'b0;
        end else begin
            la_q  <= la_start_i;
            la_q2 <= la_q;
        end
    end

    assign start_req = start_pulse | (la_q & ~la_q2);
`else
    assign start_req = start_pulse;
`endif

    // Descending loop leaves the lowest qualifying channel; the live mask is used so edits land at NEXT.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_found = 1'b1;
                first_ch    = CSW'(i);
            end
            if (chan_mask[i] && (i > int'(chan_sel_o))) begin
                next_found = 1'b1;
                next_ch    = CSW'(i);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            chan_sel_o <= '0;
            sample_o   <= 1'b0;
            cnt        <= '0;
            settle_lat <= '0;
            hold_lat   <= '0;
            tgt_ch     <= '0;
        end else if (abort_pulse) begin
            state      <= ST_IDLE;
            chan_sel_o <= '0;
            sample_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    chan_sel_o <= '0;
                    sample_o   <= 1'b0;
                    if (start_req && first_found) begin
                        tgt_ch <= first_ch;
                        state  <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    chan_sel_o <= tgt_ch;
                    settle_lat <= settle_cycles;
                    hold_lat   <= hold_cycles;
                    cnt        <= 16'd1;
                    state      <= ST_SETTLE;
                end
                // Counters start at 1 so a programmed 0 still yields one cycle.
                ST_SETTLE: begin
                    if (cnt >= settle_lat) begin
                        state    <= ST_SAMPLE;
                        sample_o <= 1'b1;
                        cnt      <= 16'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt >= hold_lat) begin
                        state    <= ST_CAPTURE;
                        sample_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_CAPTURE: state <= ST_NEXT;
                ST_NEXT: begin
                    if (next_found) begin
                        tgt_ch <= next_ch;
                        state  <= ST_SELECT;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (continuous && first_found) begin
                        tgt_ch <= first_ch;
                        state  <= ST_SELECT;
                    end else begin
                        chan_sel_o <= '0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_analog_scan_sequencer.sv
// Self-checking bench for analog_scan_sequencer: scenario tasks with queued expected results.
module tb_analog_scan_sequencer;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_TIMING = BASE + 32'h04;
    localparam logic [31:0] A_STATUS = BASE + 32'h08;
    localparam logic [31:0] A_DATA   = BASE + 32'h40;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic [2:0]  chan_sel_o;
    logic        sample_o;
    logic [11:0] adc_data_i;
    logic        irq_o;
`ifdef ANALOG_SCAN_LA_EN
    logic        la_start_i = 1'b0;
`endif

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q [$];
    logic [2:0]  chan_q [$];

    analog_scan_sequencer dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .chan_sel_o (chan_sel_o),
        .sample_o   (sample_o),
        .adc_data_i (adc_data_i),
        .irq_o      (irq_o)
`ifdef ANALOG_SCAN_LA_EN
        ,
        .la_start_i (la_start_i)
`endif
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bit acked = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        for (int n = 0; n < 10; n++) begin
            step();
            if (wbs_ack_o) begin
                acked = 1'b1;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (!acked) begin
            total_cnt++;
            $display("[TB] FAIL write_ack: adr 0x%h got no ack, required ack within 10 cycles", adr);
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat, output bit acked);
        acked     = 1'b0;
        dat       = 32'hDEAD_BEEF;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = adr;
        wbs_sel_i = 4'hF;
        for (int n = 0; n < 10; n++) begin
            step();
            if (wbs_ack_o) begin
                acked = 1'b1;
                dat   = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] e;
        bit          ack;
        wb_rst_i   = 1'b1;
        wbs_cyc_i  = 1'b0;
        wbs_stb_i  = 1'b0;
        wbs_we_i   = 1'b0;
        wbs_sel_i  = 4'h0;
        wbs_adr_i  = '0;
        wbs_dat_i  = '0;
        adc_data_i = '0;
        repeat (3) step();
        total_cnt++;
        if ({irq_o, sample_o, chan_sel_o, wbs_ack_o} !== 6'b0)
            $display("[TB] FAIL reset_outputs: got irq=%b sample=%b chan=%0d ack=%b, required all 0", irq_o, sample_o, chan_sel_o, wbs_ack_o);
        else pass_cnt++;
        wb_rst_i = 1'b0;
        step();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        wb_read(A_STATUS, rd, ack);
        e = exp_q.pop_front();
        total_cnt++;
        if (rd !== e) $display("[TB] FAIL reset_status: got 0x%h, required 0x%h", rd, e); else pass_cnt++;
        wb_read(A_CTRL, rd, ack);
        e = exp_q.pop_front();
        total_cnt++;
        if (rd !== e) $display("[TB] FAIL reset_ctrl: got 0x%h, required 0x%h", rd, e); else pass_cnt++;
        wb_read(A_TIMING, rd, ack);
        e = exp_q.pop_front();
        total_cnt++;
        if (rd !== e) $display("[TB] FAIL reset_timing: got 0x%h, required 0x%h", rd, e); else pass_cnt++;
        total_cnt++;
        if ({irq_o, chan_sel_o} !== 4'b0)
            $display("[TB] FAIL idle_outputs: got irq=%b chan=%0d, required 0/0", irq_o, chan_sel_o);
        else pass_cnt++;
    endtask

    task automatic test_scan();
        logic [31:0] rd;
        logic [31:0] e;
        logic [2:0]  ec;
        bit          ack;
        int          lat;
        int          hi;
        int          lo;
        logic [31:0] addrs [4];
        addrs = '{A_STATUS, A_DATA, A_DATA + 32'h4, A_DATA + 32'h8};
        adc_data_i = 12'hABC;
        chan_q.push_back(3'd0);
        chan_q.push_back(3'd2);
        wb_write(A_TIMING, 32'h0002_0003, 4'hF);
        wb_write(A_CTRL, 32'h0000_0501, 4'hF);
        lat = 0;
        for (int n = 1; n <= 50; n++) begin
            step();
            if (sample_o) begin
                lat = n;
                break;
            end
        end
        total_cnt++;
        if (lat != 5) $display("[TB] FAIL first_sample_latency: got %0d cycles, required 5", lat); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                lo = 0;
                while (!sample_o && lo < 50) begin
                    lo++;
                    step();
                end
                total_cnt++;
                if (lo != 6) $display("[TB] FAIL inter_channel_gap: got %0d low cycles, required 6", lo); else pass_cnt++;
            end
            ec = chan_q.pop_front();
            total_cnt++;
            if (chan_sel_o !== ec) $display("[TB] FAIL sample_channel: got %0d, required %0d", chan_sel_o, ec); else pass_cnt++;
            hi = 0;
            while (sample_o && hi < 50) begin
                hi++;
                step();
            end
            total_cnt++;
            if (hi != 2) $display("[TB] FAIL hold_length ch%0d: got %0d cycles, required 2", ec, hi); else pass_cnt++;
        end
        repeat (4) step();
        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'h0000_0ABC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0ABC);
        foreach (addrs[i]) begin
            wb_read(addrs[i], rd, ack);
            e = exp_q.pop_front();
            total_cnt++;
            if (rd !== e) $display("[TB] FAIL scan_read 0x%h: got 0x%h, required 0x%h", addrs[i], rd, e); else pass_cnt++;
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic [31:0] e;
        bit          ack;
        bit          seen;
        wb_write(A_STATUS, 32'h0000_0002, 4'hF);
        wb_write(A_CTRL, 32'h0000_0505, 4'hF);
        total_cnt++;
        if (irq_o !== 1'b0) $display("[TB] FAIL irq_before_done: got %b, required 0", irq_o); else pass_cnt++;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (irq_o) begin
                seen = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!seen) $display("[TB] FAIL irq_after_done: got no irq in 100 cycles, required irq high"); else pass_cnt++;
        wb_write(A_STATUS, 32'h0000_0002, 4'hF);
        step();
        total_cnt++;
        if (irq_o !== 1'b0) $display("[TB] FAIL irq_after_w1c: got %b, required 0", irq_o); else pass_cnt++;
        exp_q.push_back(32'h0);
        wb_read(A_STATUS, rd, ack);
        e = exp_q.pop_front();
        total_cnt++;
        if (rd !== e) $display("[TB] FAIL status_after_w1c: got 0x%h, required 0x%h", rd, e); else pass_cnt++;
    endtask

    task automatic test_continuous();
        logic [31:0] rd;
        logic [31:0] e;
        bit          ack;
        int          rises;
        logic        prev;
        wb_write(A_CTRL, 32'h0000_8003, 4'hF);
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 60 && !sample_o; n++) step();
            total_cnt++;
            if (sample_o !== 1'b1 || chan_sel_o !== 3'd7)
                $display("[TB] FAIL continuous_pass%0d: got sample=%b chan=%0d, required 1/7", r, sample_o, chan_sel_o);
            else pass_cnt++;
            if (r == 0) for (int n = 0; n < 60 && sample_o; n++) step();
        end
        repeat (5) step();
        wb_write(A_CTRL, 32'h0000_8000, 4'hF);
        wb_write(A_STATUS, 32'h0000_0002, 4'hF);
        rises = 0;
        prev  = sample_o;
        for (int n = 0; n < 60; n++) begin
            step();
            if (sample_o && !prev) rises++;
            prev = sample_o;
        end
        total_cnt++;
        if (rises != 1) $display("[TB] FAIL scans_after_cont_clear: got %0d, required 1", rises); else pass_cnt++;
        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'h0000_8000);
        wb_read(A_STATUS, rd, ack);
        e = exp_q.pop_front();
        total_cnt++;
        if (rd !== e) $display("[TB] FAIL status_after_cont: got 0x%h, required 0x%h", rd, e); else pass_cnt++;
        wb_read(A_CTRL, rd, ack);
        e = exp_q.pop_front();
        total_cnt++;
        if (rd !== e) $display("[TB] FAIL ctrl_after_cont: got 0x%h, required 0x%h", rd, e); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic [31:0] e;
        bit          ack;
        logic [31:0] addrs [5];
        addrs = '{A_STATUS, A_DATA, A_CTRL, A_STATUS, A_STATUS};
        wb_write(A_TIMING, 32'h000A_0002, 4'hF);
        wb_write(A_STATUS, 32'h0000_0002, 4'hF);
        adc_data_i = 12'h123;
        wb_write(A_CTRL, 32'h0000_0501, 4'hF);
        for (int n = 0; n < 60 && !sample_o; n++) step();
        repeat (2) step();
        wb_write(A_CTRL, 32'h0000_0508, 4'hF);
        step();
        total_cnt++;
        if (sample_o !== 1'b0 || chan_sel_o !== 3'd0)
            $display("[TB] FAIL abort_outputs: got sample=%b chan=%0d, required 0/0", sample_o, chan_sel_o);
        else pass_cnt++;
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0ABC);
        exp_q.push_back(32'h0000_0500);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) wb_write(A_CTRL, 32'h0000_0001, 4'hF);
            if (i == 4) wb_write(A_CTRL, 32'h0000_0509, 4'hF);
            if (i >= 3) repeat (3) step();
            wb_read(addrs[i], rd, ack);
            e = exp_q.pop_front();
            total_cnt++;
            if (rd !== e) $display("[TB] FAIL abort_read%0d 0x%h: got 0x%h, required 0x%h", i, addrs[i], rd, e); else pass_cnt++;
        end
    endtask

    task automatic test_bus();
        logic [31:0] rd;
        logic [31:0] e;
        bit          ack;
        wb_read(BASE + 32'h200, rd, ack);
        total_cnt++;
        if (ack !== 1'b0) $display("[TB] FAIL out_of_window_ack: got ack=%b, required 0", ack); else pass_cnt++;
        exp_q.push_back(32'h0);
        wb_read(BASE + 32'h3C, rd, ack);
        e = exp_q.pop_front();
        total_cnt++;
        if (rd !== e) $display("[TB] FAIL unmapped_read: got 0x%h, required 0x%h", rd, e); else pass_cnt++;
        wb_write(A_TIMING, 32'h0002_0003, 4'hF);
        wb_write(A_TIMING, 32'hFFFF_FFFF, 4'h2);
        exp_q.push_back(32'h0002_FF03);
        wb_read(A_TIMING, rd, ack);
        e = exp_q.pop_front();
        total_cnt++;
        if (rd !== e) $display("[TB] FAIL byte_write_timing: got 0x%h, required 0x%h", rd, e); else pass_cnt++;
        wb_write(A_DATA + 32'h8, 32'h0000_0000, 4'hF);
        exp_q.push_back(32'h0000_0ABC);
        wb_read(A_DATA + 32'h8, rd, ack);
        e = exp_q.pop_front();
        total_cnt++;
        if (rd !== e) $display("[TB] FAIL data_write_ignored: got 0x%h, required 0x%h", rd, e); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_irq();
        test_continuous();
        test_abort();
        test_bus();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
